bcd_timekeeper: RTL

- Upstream time source for the VGA clock display. Holds hours/minutes/seconds as BCD digits and advances them once per second from a clock-cycle prescaler.
- Three adjust buttons are synchronised, debounced and auto-repeated before they increment their field.
- Outputs feed the digit-selection / font path directly, one register per digit.

---
 rtl/bcd_timekeeper_pkg.sv | 78 +++++++
 rtl/bcd_timekeeper_button_repeat.sv | 124 ++++++++++++
 rtl/bcd_timekeeper.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bcd_timekeeper_pkg.sv
// -----------------------------------------------------------------------------
// timekeeper_pkg
// Shared definitions for the BCD timekeeper:
//   - power-on / reset time constants (09:10:00)
//   - repeat FSM state encoding used by button_repeat
//   - BCD field increment helpers (00..59, 00..23, 12-hour 01..12)
// -----------------------------------------------------------------------------
package timekeeper_pkg;

  localparam logic [1:0] RST_HRS_D = 2'd0;
  localparam logic [3:0] RST_HRS_U = 4'd9;
  localparam logic [2:0] RST_MIN_D = 3'd1;
  localparam logic [3:0] RST_MIN_U = 4'd0;
  localparam logic [2:0] RST_SEC_D = 3'd0;
  localparam logic [3:0] RST_SEC_U = 4'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // {tens[2:0], units[3:0]} advanced by one within 00..59; wraps without carry.
  function automatic logic [6:0] bcd59_inc(input logic [6:0] val);
    logic [2:0] d;
    logic [3:0] u;
    d = val[6:4];
    u = val[3:0];
    if (u == 4'd9) begin
      u = 4'd0;
      if (d == 3'd5) begin
        d = 3'd0;
      end else begin
        d = d + 3'd1;
      end
    end else begin
      u = u + 4'd1;
    end
    return {d, u};
  endfunction

  // {tens[1:0], units[3:0]} advanced by one within 00..23.
  function automatic logic [5:0] hrs24_inc(input logic [5:0] val);
    logic [1:0] d;
    logic [3:0] u;
    d = val[5:4];
    u = val[3:0];
    if ((d == 2'd2) && (u == 4'd3)) begin
      d = 2'd0;
      u = 4'd0;
    end else if (u == 4'd9) begin
      d = d + 2'd1;
      u = 4'd0;
    end else begin
      u = u + 4'd1;
    end
    return {d, u};
  endfunction

  // {tens[1:0], units[3:0]} advanced by one in the sequence 12,01,02..11,12.
  function automatic logic [5:0] hrs12_inc(input logic [5:0] val);
    logic [1:0] d;
    logic [3:0] u;
    d = val[5:4];
    u = val[3:0];
    if ((d == 2'd1) && (u == 4'd2)) begin
      d = 2'd0;
      u = 4'd1;
    end else if (u == 4'd9) begin
      d = 2'd1;
      u = 4'd0;
    end else begin
      u = u + 4'd1;
    end
    return {d, u};
  endfunction

endpackage

// File: rtl/bcd_timekeeper_button_repeat.sv
// -----------------------------------------------------------------------------
// button_repeat
// One adjust button: 2-FF synchroniser, counter debouncer and auto-repeat FSM.
// A debounced press emits one rep strobe immediately, another after
// REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles until release.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-high reset
//   btn    in  raw asynchronous button level
//   rep    out registered one-cycle increment request
// -----------------------------------------------------------------------------
module button_repeat
  import timekeeper_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65_536,
  parameter int REPEAT_DELAY    = 15_750_000,
  parameter int REPEAT_PERIOD   = 7_875_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rep
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

  localparam logic [DB_W-1:0] DB_TERM     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] DELAY_TERM  = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] PERIOD_TERM = RP_W'(REPEAT_PERIOD - 1);

  logic            sync_meta_r;
  logic            sync_r;
  logic            deb_r;
  logic            deb_prev_r;
  logic [DB_W-1:0] db_cnt_r;
  rep_state_t      state_r;
  logic [RP_W-1:0] rp_cnt_r;
  logic            rep_r;
  logic            rise_s;

  assign rise_s = deb_r & ~deb_prev_r;
  assign rep    = rep_r;

  // Two-stage synchroniser for the raw button level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta_r <= 1'b0;
      sync_r      <= 1'b0;
    end else begin
      sync_meta_r <= btn;
      sync_r      <= sync_meta_r;
    end
  end

  // Debouncer: level must differ for DEBOUNCE_CYCLES consecutive samples to flip.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_r      <= 1'b0;
      deb_prev_r <= 1'b0;
      db_cnt_r   <= {DB_W{1'b0}};
    end else begin
      deb_prev_r <= deb_r;
      if (sync_r == deb_r) begin
        db_cnt_r <= {DB_W{1'b0}};
      end else if (db_cnt_r == DB_TERM) begin
        deb_r    <= ~deb_r;
        db_cnt_r <= {DB_W{1'b0}};
      end else begin
        db_cnt_r <= db_cnt_r + RP_W'(0) + DB_W'(1);
      end
    end
  end

  // Repeat FSM; a released button forces IDLE before any other decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      rp_cnt_r <= {RP_W{1'b0}};
      rep_r    <= 1'b0;
    end else begin
      rep_r <= 1'b0;
      if (!deb_r) begin
        state_r  <= IDLE;
        rp_cnt_r <= {RP_W{1'b0}};
      end else begin
        case (state_r)
          IDLE: begin
            rp_cnt_r <= {RP_W{1'b0}};
            if (rise_s) begin
              rep_r   <= 1'b1;
              state_r <= DELAY;
            end else begin
              state_r <= IDLE;
            end
          end
          DELAY: begin
            if (rp_cnt_r == DELAY_TERM) begin
              rep_r    <= 1'b1;
              state_r  <= REPEAT;
              rp_cnt_r <= {RP_W{1'b0}};
            end else begin
              rp_cnt_r <= rp_cnt_r + RP_W'(1);
            end
          end
          REPEAT: begin
            if (rp_cnt_r == PERIOD_TERM) begin
              rep_r    <= 1'b1;
              rp_cnt_r <= {RP_W{1'b0}};
            end else begin
              rp_cnt_r <= rp_cnt_r + RP_W'(1);
            end
          end
          default: begin
            state_r  <= IDLE;
            rp_cnt_r <= {RP_W{1'b0}};
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/bcd_timekeeper.sv
// -----------------------------------------------------------------------------
// bcd_timekeeper
// BCD hours/minutes/seconds timekeeper advanced by a CLK_HZ prescaler, with
// three debounced auto-repeat adjust buttons.
// Build option: define TIMEKEEPER_12H_EN for 12-hour operation with pm flag;
// otherwise 24-hour operation with pm tied low.
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   adj_hrs/adj_min/adj_sec    raw async adjust buttons
//   hrs_d/hrs_u, min_d/min_u,  registered BCD digits
//   sec_d/sec_u
//   sec_pulse                  one-cycle strobe per prescaler second
//   pm                         PM flag (12-hour build only)
// -----------------------------------------------------------------------------
module bcd_timekeeper
  import timekeeper_pkg::*;
#(
  parameter int CLK_HZ          = 31_500_000,
  parameter int DEBOUNCE_CYCLES = 65_536,
  parameter int REPEAT_DELAY    = 15_750_000,
  parameter int REPEAT_PERIOD   = 7_875_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       adj_hrs,
  input  logic       adj_min,
  input  logic       adj_sec,
  output logic [1:0] hrs_d,
  output logic [3:0] hrs_u,
  output logic [2:0] min_d,
  output logic [3:0] min_u,
  output logic [2:0] sec_d,
  output logic [3:0] sec_u,
  output logic       sec_pulse,
  output logic       pm
);

  localparam int PS_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PS_W-1:0] PS_TERM = PS_W'(CLK_HZ - 1);

  logic [PS_W-1:0] ps_cnt_r;
  logic            sec_pulse_r;
  logic [1:0]      hrs_d_r;
  logic [3:0]      hrs_u_r;
  logic [2:0]      min_d_r;
  logic [3:0]      min_u_r;
  logic [2:0]      sec_d_r;
  logic [3:0]      sec_u_r;
  logic            pm_r;

  logic            tick_s;
  logic            rep_sec_s, rep_min_s, rep_hrs_s;
  logic            sec_carry_s, min_carry_s;
  logic            inc_sec_s, inc_min_s, inc_hrs_s;
  logic [5:0]      hrs_next_s;
  logic            pm_next_s;

  button_repeat #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_btn_sec (.clk(clk), .reset(reset), .btn(adj_sec), .rep(rep_sec_s));

  button_repeat #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_btn_min (.clk(clk), .reset(reset), .btn(adj_min), .rep(rep_min_s));

  button_repeat #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_btn_hrs (.clk(clk), .reset(reset), .btn(adj_hrs), .rep(rep_hrs_s));

  assign tick_s = (ps_cnt_r == PS_TERM);

  // Only the tick path carries; adjust strobes wrap within their own field.
  assign sec_carry_s = tick_s & (sec_d_r == 3'd5) & (sec_u_r == 4'd9);
  assign min_carry_s = sec_carry_s & (min_d_r == 3'd5) & (min_u_r == 4'd9);

  // OR-ing the sources means a field still advances by exactly one per cycle.
  assign inc_sec_s = tick_s | rep_sec_s;
  assign inc_min_s = sec_carry_s | rep_min_s;
  assign inc_hrs_s = min_carry_s | rep_hrs_s;

  // Next hour value and pm flag for the selected hour format.
  always_comb begin
    hrs_next_s = {hrs_d_r, hrs_u_r};
    pm_next_s  = pm_r;
`ifdef TIMEKEEPER_12H_EN
    hrs_next_s = hrs12_inc({hrs_d_r, hrs_u_r});
    if ((hrs_d_r == 2'd1) && (hrs_u_r == 4'd1)) begin
      pm_next_s = ~pm_r;
    end else begin
      pm_next_s = pm_r;
    end
`else
    hrs_next_s = hrs24_inc({hrs_d_r, hrs_u_r});
    pm_next_s  = 1'b0;
`endif
  end

  // Prescaler: counts 0..CLK_HZ-1; the terminal cycle is the second tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_cnt_r    <= {PS_W{1'b0}};
      sec_pulse_r <= 1'b0;
    end else begin
      sec_pulse_r <= tick_s;
      if (tick_s) begin
        ps_cnt_r <= {PS_W{1'b0}};
      end else begin
        ps_cnt_r <= ps_cnt_r + PS_W'(1);
      end
    end
  end

  // Time digit registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hrs_d_r <= RST_HRS_D;
      hrs_u_r <= RST_HRS_U;
      min_d_r <= RST_MIN_D;
      min_u_r <= RST_MIN_U;
      sec_d_r <= RST_SEC_D;
      sec_u_r <= RST_SEC_U;
      pm_r    <= 1'b0;
    end else begin
      if (inc_sec_s) begin
        {sec_d_r, sec_u_r} <= bcd59_inc({sec_d_r, sec_u_r});
      end else begin
        {sec_d_r, sec_u_r} <= {sec_d_r, sec_u_r};
      end
      if (inc_min_s) begin
        {min_d_r, min_u_r} <= bcd59_inc({min_d_r, min_u_r});
      end else begin
        {min_d_r, min_u_r} <= {min_d_r, min_u_r};
      end
      if (inc_hrs_s) begin
        {hrs_d_r, hrs_u_r} <= hrs_next_s;
        pm_r               <= pm_next_s;
      end else begin
        {hrs_d_r, hrs_u_r} <= {hrs_d_r, hrs_u_r};
        pm_r               <= pm_r;
      end
    end
  end

  assign hrs_d     = hrs_d_r;
  assign hrs_u     = hrs_u_r;
  assign min_d     = min_d_r;
  assign min_u     = min_u_r;
  assign sec_d     = sec_d_r;
  assign sec_u     = sec_u_r;
  assign sec_pulse = sec_pulse_r;
  assign pm        = pm_r;

endmodule
